// File: rtl/core_uart_tx_arbiter.sv
// Round-robin byte arbiter feeding a single UART transmitter holding register.
// Define CORE_UART_ARB_LOCK_EN to build the burst-lock (sticky grant) feature.
module core_uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_lock,
  input  logic              tx_rdy,
  output logic              tx_wen,
  output logic [7:0]        tx_data,
  output logic [NREQ-1:0]   req_ack,
  output logic [1:0]        grant_id,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_HOLD, S_WAIT} state_e;

  state_e          state_q, state_d;
  logic            tx_wen_q, tx_wen_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [NREQ-1:0] req_ack_q, req_ack_d;
  logic [1:0]      grant_id_q, grant_id_d;

  logic            rr_hit, pick_hit;
  logic [1:0]      rr_idx, pick_idx;
  logic            take;

  // First requester after the last grantee, wrapping at NREQ-1.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = grant_id_q;
    for (int k = 1; k <= NREQ; k++) begin
      if (!rr_hit && req[(int'(grant_id_q) + k) % NREQ]) begin
        rr_hit = 1'b1;
        rr_idx = 2'((int'(grant_id_q) + k) % NREQ);
      end
    end
  end

`ifdef CORE_UART_ARB_LOCK_EN
  logic [3:0] burst_q, burst_d;
  logic       lock_hit;

  // burst_q counts re-grants, so MAX_BURST bytes in a row means MAX_BURST-1 re-grants.
  always_comb begin
    lock_hit = req[int'(grant_id_q)] && req_lock[int'(grant_id_q)] &&
               (burst_q < 4'(MAX_BURST - 1));
    pick_hit = lock_hit || rr_hit;
    pick_idx = lock_hit ? grant_id_q : rr_idx;
    burst_d  = burst_q;
    if (take) burst_d = lock_hit ? burst_q + 4'd1 : 4'd0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) burst_q <= 4'd0;
    else          burst_q <= burst_d;
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;

  always_comb begin
    pick_hit = rr_hit;
    pick_idx = rr_idx;
  end
`endif

  assign take = (state_q == S_IDLE) && tx_rdy && pick_hit;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      tx_wen_q   <= 1'b0;
      tx_data_q  <= 8'h00;
      req_ack_q  <= '0;
      grant_id_q <= 2'(NREQ - 1);
    end else begin
      state_q    <= state_d;
      tx_wen_q   <= tx_wen_d;
      tx_data_q  <= tx_data_d;
      req_ack_q  <= req_ack_d;
      grant_id_q <= grant_id_d;
    end
  end

  // HOLD waits out the registered fall of tx_rdy before WAIT looks at it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (take)   state_d = S_WRITE;
      S_WRITE:             state_d = S_HOLD;
      S_HOLD:              state_d = S_WAIT;
      S_WAIT:  if (tx_rdy) state_d = S_IDLE;
      default:             state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_wen_d   = 1'b0;
    req_ack_d  = '0;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    if (take) begin
      tx_wen_d                 = 1'b1;
      req_ack_d[int'(pick_idx)] = 1'b1;
      tx_data_d                = req_data[int'(pick_idx)*8 +: 8];
      grant_id_d               = pick_idx;
    end
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    tx_wen   = tx_wen_q;
    tx_data  = tx_data_q;
    req_ack  = req_ack_q;
    grant_id = grant_id_q;
  end

endmodule

// File: tb/tb_core_uart_tx_arbiter.sv
// Directed bench for core_uart_tx_arbiter with a small Tx_async tx_rdy model.
module tb_core_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int MAX_BURST = 3;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_lock = '0;
  logic        drv_rdy = 1'b0;
  logic        model_en = 1'b0;
  logic        model_rdy;
  logic        tx_rdy;
  logic        tx_wen;
  logic [7:0]  tx_data;
  logic [3:0]  req_ack;
  logic [1:0]  grant_id;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int mcnt;

  core_uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .req(req), .req_data(req_data),
    .req_lock(req_lock), .tx_rdy(tx_rdy), .tx_wen(tx_wen), .tx_data(tx_data),
    .req_ack(req_ack), .grant_id(grant_id), .busy(busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  assign tx_rdy = model_en ? model_rdy : drv_rdy;

  // Holding register goes busy after a write and frees up a few cycles later.
  always @(negedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      model_rdy <= 1'b1;
      mcnt      <= 0;
    end else if (tx_wen) begin
      model_rdy <= 1'b0;
      mcnt      <= 3;
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end else if (mcnt == 1) begin
      mcnt      <= 0;
      model_rdy <= 1'b1;
    end
  end

  task automatic do_reset;
    RESET_N = 1'b0;
    req = '0;
    req_lock = '0;
    drv_rdy = 1'b0;
    model_en = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic wait_wen(input int budget, output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge CLK); #1;
      if (tx_wen) begin ok = 1'b1; at = cyc; end
    end
  endtask

  task automatic test_reset;
    #1 RESET_N = 1'b0;
    #1;
    n_chk++; if (tx_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen got %b exp 0", tx_wen); end
    n_chk++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", tx_data); end
    n_chk++; if (req_ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got %b exp 0000", req_ack); end
    n_chk++; if (grant_id !== 2'd3) begin n_fail++; $display("FAIL reset_grant got %0d exp 3", grant_id); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    @(negedge CLK); @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_single;
    model_en = 1'b0;
    drv_rdy = 1'b1;
    req_data[7:0] = 8'hA5;
    req = 4'b0001;
    @(posedge CLK); #1;
    n_chk++; if (tx_wen !== 1'b1) begin n_fail++; $display("FAIL single_wen got %b exp 1", tx_wen); end
    n_chk++; if (req_ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack got %b exp 0001", req_ack); end
    n_chk++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h exp a5", tx_data); end
    n_chk++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL single_grant got %0d exp 0", grant_id); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b exp 1", busy); end
    @(negedge CLK) req = '0;
    @(posedge CLK); #1;
    n_chk++; if ({tx_wen, req_ack} !== 5'b0) begin n_fail++; $display("FAIL single_pulse_end got %b exp 00000", {tx_wen, req_ack}); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_hold_busy got %b exp 1", busy); end
  endtask

  task automatic test_round_robin;
    int exp_g[5] = '{0, 1, 2, 3, 0};
    bit ok;
    int at, last;
    logic [7:0] d;
    do_reset();
    model_en = 1'b1;
    req_data = 32'h44332211;
    req = 4'b1111;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      wait_wen(30, ok, at);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL rr_timeout k=%0d got none exp tx_wen", k); end
      if (ok) begin
        d = req_data[exp_g[k]*8 +: 8];
        n_chk++; if (grant_id !== 2'(exp_g[k])) begin n_fail++; $display("FAIL rr_grant k=%0d got %0d exp %0d", k, grant_id, exp_g[k]); end
        n_chk++; if (req_ack !== 4'(1 << exp_g[k])) begin n_fail++; $display("FAIL rr_ack k=%0d got %b exp %b", k, req_ack, 4'(1 << exp_g[k])); end
        n_chk++; if (tx_data !== d) begin n_fail++; $display("FAIL rr_data k=%0d got %h exp %h", k, tx_data, d); end
        if (k > 0) begin
          n_chk++; if (at - last < 4) begin n_fail++; $display("FAIL rr_spacing k=%0d got %0d exp >=4", k, at - last); end
        end
        last = at;
      end
    end
    @(negedge CLK) req = '0;
  endtask

  task automatic test_tx_rdy_low;
    int pulses, busies;
    do_reset();
    req_data[23:16] = 8'h5A;
    req = 4'b0100;
    pulses = 0;
    busies = 0;
    repeat (20) begin
      @(posedge CLK); #1;
      if (tx_wen) pulses++;
      if (busy) busies++;
    end
    n_chk++; if (pulses != 0) begin n_fail++; $display("FAIL rdylow_wen got %0d exp 0", pulses); end
    n_chk++; if (busies != 0) begin n_fail++; $display("FAIL rdylow_busy got %0d exp 0", busies); end
    @(negedge CLK) drv_rdy = 1'b1;
    @(posedge CLK); #1;
    n_chk++; if (tx_wen !== 1'b1) begin n_fail++; $display("FAIL rdyrise_wen got %b exp 1", tx_wen); end
    n_chk++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL rdyrise_grant got %0d exp 2", grant_id); end
    n_chk++; if (tx_data !== 8'h5A) begin n_fail++; $display("FAIL rdyrise_data got %h exp 5a", tx_data); end
    @(negedge CLK) req = '0;
  endtask

  task automatic test_lock;
`ifdef CORE_UART_ARB_LOCK_EN
    int exp_g[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int n = 8;
`else
    int exp_g[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    int n = 4;
`endif
    bit ok;
    int at;
    do_reset();
    model_en = 1'b1;
    req_data[15:0] = 16'hC1C0;
    req_lock = 4'b0001;
    req = 4'b0011;
    for (int k = 0; k < n; k++) begin
      wait_wen(30, ok, at);
      n_chk++;
      if (!ok) begin
        n_fail++; $display("FAIL lock_timeout k=%0d got none exp tx_wen", k);
      end else if (grant_id !== 2'(exp_g[k])) begin
        n_fail++; $display("FAIL lock_grant k=%0d got %0d exp %0d (at cycle %0d)", k, grant_id, exp_g[k], at);
      end
    end
    @(negedge CLK);
    req = '0;
    req_lock = '0;
  endtask

  task automatic test_reset_in_wait;
    do_reset();
    drv_rdy = 1'b1;
    req_data[15:0] = 16'h8877;
    req = 4'b0001;
    @(posedge CLK); #1;
    n_chk++; if (tx_wen !== 1'b1 || grant_id !== 2'd0) begin n_fail++; $display("FAIL rw_first got wen=%b g=%0d exp wen=1 g=0", tx_wen, grant_id); end
    @(negedge CLK);
    req = '0;
    drv_rdy = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rw_wait_busy got %b exp 1", busy); end
    @(negedge CLK);
    req = 4'b0010;
    #2 RESET_N = 1'b0;
    #1;
    n_chk++; if ({tx_wen, req_ack, busy} !== 6'b0) begin n_fail++; $display("FAIL rw_async_ctl got %b exp 000000", {tx_wen, req_ack, busy}); end
    n_chk++; if (tx_data !== 8'h00 || grant_id !== 2'd3) begin n_fail++; $display("FAIL rw_async_val got d=%h g=%0d exp d=00 g=3", tx_data, grant_id); end
    @(negedge CLK);
    RESET_N = 1'b1;
    drv_rdy = 1'b1;
    @(posedge CLK); #1;
    n_chk++; if (tx_wen !== 1'b1 || req_ack !== 4'b0010) begin n_fail++; $display("FAIL rw_resume got wen=%b ack=%b exp wen=1 ack=0010", tx_wen, req_ack); end
    n_chk++; if (grant_id !== 2'd1 || tx_data !== 8'h88) begin n_fail++; $display("FAIL rw_resume_val got g=%0d d=%h exp g=1 d=88", grant_id, tx_data); end
    @(negedge CLK) req = '0;
    @(posedge CLK); #1;
    n_chk++; if ({tx_wen, req_ack} !== 5'b0) begin n_fail++; $display("FAIL rw_no_dup got %b exp 00000", {tx_wen, req_ack}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_tx_rdy_low();
    test_lock();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
